// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_pkg
// Purpose  : Shared encodings for the MIPS-lite multi-cycle controller:
//            FSM state codes, opcode/funct values, ALU operation codes,
//            next-PC / register-destination / write-data select codes and
//            the one-hot instruction-class vector produced by mc_decode.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package mc_ctrl_pkg;

    // FSM states; codes 5..7 are unused and recover to FETCH
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_JAL   = 6'h03;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_JR    = 6'h08;

    // ALU operations
    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_OR   = 3'd2;
    localparam logic [2:0] ALU_LUI  = 3'd3;

    // Next-PC source
    localparam logic [1:0] PC_SEL_PC4    = 2'd0;
    localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
    localparam logic [1:0] PC_SEL_JUMP   = 2'd2;
    localparam logic [1:0] PC_SEL_RS     = 2'd3;

    // GRF write-address source
    localparam logic [1:0] REG_DST_RT = 2'd0;
    localparam logic [1:0] REG_DST_RD = 2'd1;
    localparam logic [1:0] REG_DST_RA = 2'd2;

    // GRF write-data source
    localparam logic [1:0] WD_SEL_ALU = 2'd0;
    localparam logic [1:0] WD_SEL_MDR = 2'd1;
    localparam logic [1:0] WD_SEL_PC  = 2'd2;

    // One-hot instruction class; exactly one field is set for any op/funct
    typedef struct packed {
        logic addu;
        logic subu;
        logic ori;
        logic lw;
        logic sw;
        logic beq;
        logic lui;
        logic jal;
        logic jr;
        logic nop;
    } instr_class_t;

endpackage
`default_nettype wire

// File: rtl/mc_decode.sv
`default_nettype none
// ============================================================================
// Module   : mc_decode
// Purpose  : Combinational instruction classifier. Maps op/funct to a
//            one-hot class vector; anything unrecognised (including the
//            all-zero nop) is classed as nop.
// Ports    : op_i    [5:0]  IR[31:26]
//            funct_i [5:0]  IR[5:0]
//            cls_o          one-hot instruction class
// Revision : 1.0  initial release
// ============================================================================
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0]   op_i,
    input  logic [5:0]   funct_i,
    output instr_class_t cls_o
);

    always_comb begin
        cls_o = '0;
        unique case (op_i)
            OP_RTYPE: begin
                unique case (funct_i)
                    FN_ADDU: cls_o.addu = 1'b1;
                    FN_SUBU: cls_o.subu = 1'b1;
                    FN_JR:   cls_o.jr   = 1'b1;
                    default: cls_o.nop  = 1'b1;
                endcase
            end
            OP_ORI:  cls_o.ori = 1'b1;
            OP_LW:   cls_o.lw  = 1'b1;
            OP_SW:   cls_o.sw  = 1'b1;
            OP_BEQ:  cls_o.beq = 1'b1;
            OP_LUI:  cls_o.lui = 1'b1;
            OP_JAL:  cls_o.jal = 1'b1;
            default: cls_o.nop = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl
// Purpose  : Multi-cycle control FSM for the MIPS-lite CPU. Sequences
//            FETCH/DECODE/EXEC/MEM/WB, drives every datapath write enable
//            and mux select, and counts retired instructions.
// Ports    : clk, reset          clock, synchronous active-high reset
//            op, funct, zero     IR fields and ALU equal flag
//            pc_init             constant reset PC for the datapath
//            pc_we, pc_sel       PC update enable / source
//            ir_we, ab_we        IR load, A/B operand latch
//            alu_op, alu_b_sel   ALU function / operand-B source
//            ext_op              immediate extension mode
//            mdr_we, dm_we       MDR latch, data-memory write
//            grf_we, reg_dst,    register-file write enable, address and
//            wd_sel              data source
//            retire, instr_cnt   completion pulse, retired count
//            state_o             current FSM state (debug)
// Revision : 1.0  initial release
// ============================================================================
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic [31:0]      pc_init,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             ir_we,
    output logic             ab_we,
    output logic [2:0]       alu_op,
    output logic             alu_b_sel,
    output logic             ext_op,
    output logic             mdr_we,
    output logic             dm_we,
    output logic             grf_we,
    output logic [1:0]       reg_dst,
    output logic [1:0]       wd_sel,
    output logic             retire,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [2:0]       state_o
);

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  instr_cnt_q;
    instr_class_t      w_cls;

    mc_decode u_decode (
        .op_i    (op),
        .funct_i (funct),
        .cls_o   (w_cls)
    );

    assign pc_init   = RESET_PC;
    assign instr_cnt = instr_cnt_q;
    assign state_o   = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // retire is already forced low while reset is high, so the counter
    // cannot step on a reset cycle even before the clear takes priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_cnt_q <= '0;
        end else if (retire) begin
            instr_cnt_q <= instr_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d   = S_FETCH;
        pc_we     = 1'b0;
        pc_sel    = PC_SEL_PC4;
        ir_we     = 1'b0;
        ab_we     = 1'b0;
        alu_op    = ALU_ADD;
        alu_b_sel = 1'b0;
        ext_op    = 1'b0;
        mdr_we    = 1'b0;
        dm_we     = 1'b0;
        grf_we    = 1'b0;
        reg_dst   = REG_DST_RT;
        wd_sel    = WD_SEL_ALU;
        retire    = 1'b0;

        case (state_q)
            S_FETCH: begin
                ir_we   = 1'b1;
                pc_we   = 1'b1;
                pc_sel  = PC_SEL_PC4;
                state_d = S_DECODE;
            end

            S_DECODE: begin
                ab_we = 1'b1;
                if (w_cls.jal) begin
                    // PC already holds PC+4 here, which is the link value
                    pc_we   = 1'b1;
                    pc_sel  = PC_SEL_JUMP;
                    grf_we  = 1'b1;
                    reg_dst = REG_DST_RA;
                    wd_sel  = WD_SEL_PC;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (w_cls.jr) begin
                    pc_we   = 1'b1;
                    pc_sel  = PC_SEL_RS;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (w_cls.nop) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                if (w_cls.beq) begin
                    alu_op    = ALU_SUB;
                    alu_b_sel = 1'b0;
                    if (zero) begin
                        pc_we  = 1'b1;
                        pc_sel = PC_SEL_BRANCH;
                    end
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (w_cls.lw || w_cls.sw) begin
                    alu_op    = ALU_ADD;
                    alu_b_sel = 1'b1;
                    ext_op    = 1'b1;
                    state_d   = S_MEM;
                end else if (w_cls.addu || w_cls.subu) begin
                    alu_op    = w_cls.subu ? ALU_SUB : ALU_ADD;
                    alu_b_sel = 1'b0;
                    state_d   = S_WB;
                end else if (w_cls.ori) begin
                    alu_op    = ALU_OR;
                    alu_b_sel = 1'b1;
                    ext_op    = 1'b0;
                    state_d   = S_WB;
                end else if (w_cls.lui) begin
                    alu_op    = ALU_LUI;
                    alu_b_sel = 1'b1;
                    state_d   = S_WB;
                end else begin
                    state_d = S_FETCH;
                end
            end

            S_MEM: begin
                if (w_cls.lw) begin
                    mdr_we  = 1'b1;
                    state_d = S_WB;
                end else if (w_cls.sw) begin
                    dm_we   = 1'b1;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_FETCH;
                end
            end

            S_WB: begin
                grf_we  = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
                if (w_cls.addu || w_cls.subu) begin
                    reg_dst = REG_DST_RD;
                    wd_sel  = WD_SEL_ALU;
                end else if (w_cls.lw) begin
                    reg_dst = REG_DST_RT;
                    wd_sel  = WD_SEL_MDR;
                end else begin
                    reg_dst = REG_DST_RT;
                    wd_sel  = WD_SEL_ALU;
                end
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase

        // A reset cycle must never commit a partial write, whatever state
        // the instruction had reached.
        if (reset) begin
            pc_we  = 1'b0;
            ir_we  = 1'b0;
            ab_we  = 1'b0;
            mdr_we = 1'b0;
            dm_we  = 1'b0;
            grf_we = 1'b0;
            retire = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_ctrl
// Purpose  : Directed self-checking bench for mc_ctrl. Walks every
//            instruction class through its state sequence, checks enables
//            and selects per cycle, reset mid-instruction and counter wrap
//            (counter narrowed to 4 bits so the wrap is reachable quickly).
// Revision : 1.0  initial release
// ============================================================================
module tb_mc_ctrl;

    localparam int CNT_W = 4;

    // enable bundle bit weights: {pc_we, ir_we, ab_we, mdr_we, dm_we, grf_we, retire}
    localparam int E_PC  = 64;
    localparam int E_IR  = 32;
    localparam int E_AB  = 16;
    localparam int E_MDR = 8;
    localparam int E_DM  = 4;
    localparam int E_GRF = 2;
    localparam int E_RET = 1;

    logic             clk;
    logic             reset;
    logic [5:0]       op;
    logic [5:0]       funct;
    logic             zero;
    logic [31:0]      pc_init;
    logic             pc_we;
    logic [1:0]       pc_sel;
    logic             ir_we;
    logic             ab_we;
    logic [2:0]       alu_op;
    logic             alu_b_sel;
    logic             ext_op;
    logic             mdr_we;
    logic             dm_we;
    logic             grf_we;
    logic [1:0]       reg_dst;
    logic [1:0]       wd_sel;
    logic             retire;
    logic [CNT_W-1:0] instr_cnt;
    logic [2:0]       state_o;

    int               vectors;
    int               miscompares;
    logic [CNT_W-1:0] exp_cnt;

    mc_ctrl #(
        .RESET_PC (32'h0000_3000),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .funct     (funct),
        .zero      (zero),
        .pc_init   (pc_init),
        .pc_we     (pc_we),
        .pc_sel    (pc_sel),
        .ir_we     (ir_we),
        .ab_we     (ab_we),
        .alu_op    (alu_op),
        .alu_b_sel (alu_b_sel),
        .ext_op    (ext_op),
        .mdr_we    (mdr_we),
        .dm_we     (dm_we),
        .grf_we    (grf_we),
        .reg_dst   (reg_dst),
        .wd_sel    (wd_sel),
        .retire    (retire),
        .instr_cnt (instr_cnt),
        .state_o   (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: no summary after 200000 time units");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] en_bundle();
        return 32'({pc_we, ir_we, ab_we, mdr_we, dm_we, grf_we, retire});
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance to the next sampling point (mid-cycle, away from posedge)
    task automatic step(input string tag, input int st, input int en);
        @(negedge clk);
        #1;
        chk({tag, ".state"}, 32'(state_o), 32'(st));
        chk({tag, ".en"}, en_bundle(), 32'(en));
    endtask

    // FETCH cycle of the next instruction; its op/funct are presented here
    // since the IR loads at the end of FETCH
    task automatic fetch(input string tag, input logic [5:0] o, input logic [5:0] f, input logic z);
        @(negedge clk);
        op = o;
        funct = f;
        zero = z;
        #1;
        chk({tag, ".fetch.state"}, 32'(state_o), 32'd0);
        chk({tag, ".fetch.en"}, en_bundle(), 32'(E_PC + E_IR));
        chk({tag, ".fetch.pc_sel"}, 32'(pc_sel), 32'd0);
        chk({tag, ".fetch.cnt"}, 32'(instr_cnt), 32'(exp_cnt));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_cnt     = '0;
        reset       = 1'b1;
        op          = 6'h00;
        funct       = 6'h00;
        zero        = 1'b0;

        // reset: FETCH state but all enables forced low
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst.state", 32'(state_o), 32'd0);
        chk("rst.en", en_bundle(), 32'd0);
        chk("rst.cnt", 32'(instr_cnt), 32'd0);
        chk("rst.pc_init", pc_init, 32'h0000_3000);

        // first FETCH right after reset release: addu
        @(negedge clk);
        reset = 1'b0;
        op    = 6'h00;
        funct = 6'h21;
        #1;
        chk("addu.fetch.state", 32'(state_o), 32'd0);
        chk("addu.fetch.en", en_bundle(), 32'(E_PC + E_IR));
        step("addu.dec", 1, E_AB);
        step("addu.exe", 2, 0);
        chk("addu.exe.alu_op", 32'(alu_op), 32'd0);
        chk("addu.exe.bsel", 32'(alu_b_sel), 32'd0);
        step("addu.wb", 4, E_GRF + E_RET);
        chk("addu.wb.reg_dst", 32'(reg_dst), 32'd1);
        chk("addu.wb.wd_sel", 32'(wd_sel), 32'd0);
        exp_cnt++;

        // subu
        fetch("subu", 6'h00, 6'h23, 1'b0);
        step("subu.dec", 1, E_AB);
        step("subu.exe", 2, 0);
        chk("subu.exe.alu_op", 32'(alu_op), 32'd1);
        step("subu.wb", 4, E_GRF + E_RET);
        chk("subu.wb.reg_dst", 32'(reg_dst), 32'd1);
        exp_cnt++;

        // lw: 5 cycles
        fetch("lw", 6'h23, 6'h00, 1'b0);
        step("lw.dec", 1, E_AB);
        step("lw.exe", 2, 0);
        chk("lw.exe.alu_op", 32'(alu_op), 32'd0);
        chk("lw.exe.bsel", 32'(alu_b_sel), 32'd1);
        chk("lw.exe.ext", 32'(ext_op), 32'd1);
        step("lw.mem", 3, E_MDR);
        step("lw.wb", 4, E_GRF + E_RET);
        chk("lw.wb.reg_dst", 32'(reg_dst), 32'd0);
        chk("lw.wb.wd_sel", 32'(wd_sel), 32'd1);
        exp_cnt++;

        // sw: dm_we for exactly the MEM cycle, no GRF write
        fetch("sw", 6'h2b, 6'h00, 1'b0);
        step("sw.dec", 1, E_AB);
        step("sw.exe", 2, 0);
        chk("sw.exe.ext", 32'(ext_op), 32'd1);
        chk("sw.exe.bsel", 32'(alu_b_sel), 32'd1);
        step("sw.mem", 3, E_DM + E_RET);
        exp_cnt++;

        // beq taken: zero high throughout, only honoured in EXEC
        fetch("beqT", 6'h04, 6'h00, 1'b1);
        step("beqT.dec", 1, E_AB);
        step("beqT.exe", 2, E_PC + E_RET);
        chk("beqT.exe.pc_sel", 32'(pc_sel), 32'd1);
        chk("beqT.exe.alu_op", 32'(alu_op), 32'd1);
        chk("beqT.exe.bsel", 32'(alu_b_sel), 32'd0);
        exp_cnt++;

        // beq not taken
        fetch("beqN", 6'h04, 6'h00, 1'b0);
        step("beqN.dec", 1, E_AB);
        step("beqN.exe", 2, E_RET);
        exp_cnt++;

        // jal: 2 cycles, link write in DECODE
        fetch("jal", 6'h03, 6'h00, 1'b1);
        step("jal.dec", 1, E_PC + E_AB + E_GRF + E_RET);
        chk("jal.dec.pc_sel", 32'(pc_sel), 32'd2);
        chk("jal.dec.reg_dst", 32'(reg_dst), 32'd2);
        chk("jal.dec.wd_sel", 32'(wd_sel), 32'd2);
        exp_cnt++;

        // jr
        fetch("jr", 6'h00, 6'h08, 1'b0);
        step("jr.dec", 1, E_PC + E_AB + E_RET);
        chk("jr.dec.pc_sel", 32'(pc_sel), 32'd3);
        exp_cnt++;

        // ori
        fetch("ori", 6'h0d, 6'h00, 1'b0);
        step("ori.dec", 1, E_AB);
        step("ori.exe", 2, 0);
        chk("ori.exe.alu_op", 32'(alu_op), 32'd2);
        chk("ori.exe.bsel", 32'(alu_b_sel), 32'd1);
        chk("ori.exe.ext", 32'(ext_op), 32'd0);
        step("ori.wb", 4, E_GRF + E_RET);
        chk("ori.wb.reg_dst", 32'(reg_dst), 32'd0);
        chk("ori.wb.wd_sel", 32'(wd_sel), 32'd0);
        exp_cnt++;

        // lui
        fetch("lui", 6'h0f, 6'h00, 1'b0);
        step("lui.dec", 1, E_AB);
        step("lui.exe", 2, 0);
        chk("lui.exe.alu_op", 32'(alu_op), 32'd3);
        chk("lui.exe.bsel", 32'(alu_b_sel), 32'd1);
        step("lui.wb", 4, E_GRF + E_RET);
        chk("lui.wb.reg_dst", 32'(reg_dst), 32'd0);
        exp_cnt++;

        // illegal op: treated as nop, 2 cycles, no writes
        fetch("ill", 6'h3f, 6'h00, 1'b0);
        step("ill.dec", 1, E_AB + E_RET);
        exp_cnt++;

        // sll $0 nop
        fetch("nop", 6'h00, 6'h00, 1'b0);
        step("nop.dec", 1, E_AB + E_RET);
        exp_cnt++;

        // reset asserted during lw MEM
        fetch("lwrst", 6'h23, 6'h00, 1'b0);
        step("lwrst.dec", 1, E_AB);
        step("lwrst.exe", 2, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("lwrst.mem.state", 32'(state_o), 32'd3);
        chk("lwrst.mem.en", en_bundle(), 32'd0);
        @(negedge clk);
        #1;
        chk("lwrst.after.state", 32'(state_o), 32'd0);
        chk("lwrst.after.en", en_bundle(), 32'd0);
        chk("lwrst.after.cnt", 32'(instr_cnt), 32'd0);
        exp_cnt = '0;
        reset = 1'b0;
        #1;
        chk("lwrst.rel.en", en_bundle(), 32'(E_PC + E_IR));

        // counter wrap: 15 nops bring the count to all-ones, one more wraps
        op = 6'h3f;
        funct = 6'h00;
        for (int i = 0; i < 15; i++) begin
            step("wrap.dec", 1, E_AB + E_RET);
            exp_cnt++;
            fetch("wrap", 6'h3f, 6'h00, 1'b0);
        end
        chk("wrap.full", 32'(instr_cnt), 32'hF);
        step("wrap.last", 1, E_AB + E_RET);
        exp_cnt++;
        fetch("wrap.zero", 6'h00, 6'h00, 1'b0);
        chk("wrap.cnt0", 32'(instr_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle control FSM for the MIPS-lite CPU. It sequences the shared fetch unit, ALU, GRF and DM over several cycles per instruction, replacing the single-cycle one-instruction-per-clock PC update.
- Sits beside the datapath. It consumes op/funct from the instruction register and the ALU zero flag, and drives every register write-enable and mux select.
- Also maintains a retired-instruction counter for the bench.

Parameters:
- RESET_PC, 32'h0000_3000, PC value the datapath loads on reset; passed through on pc_init.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- op  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU equal flag from the EXEC-cycle compare
- pc_init  out  32  constant RESET_PC
- pc_we  out  1  PC register write enable
- pc_sel  out  2  next-PC source: 0=PC+4, 1=branch, 2=jump(imm26), 3=rs(jr)
- ir_we  out  1  IR load enable
- ab_we  out  1  latch GRF read data into A/B
- alu_op  out  3  0=ADD, 1=SUB, 2=OR, 3=LUI
- alu_b_sel  out  1  0=B register, 1=extended immediate
- ext_op  out  1  0=zero-extend, 1=sign-extend
- mdr_we  out  1  latch DM read data
- dm_we  out  1  DM write enable
- grf_we  out  1  GRF write enable
- reg_dst  out  2  0=rt, 1=rd, 2=$31
- wd_sel  out  2  0=ALU out, 1=MDR, 2=PC (already incremented)
- retire  out  1  one-cycle pulse when an instruction completes
- instr_cnt  out  CNT_W  count of retired instructions
- state_o  out  3  current state, for debug

Behaviour:
- States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Codes 5..7 are illegal and go to FETCH on the next clock.
- Outputs are Moore/Mealy combinational from state plus op/funct/zero. Every enable is 0 unless listed for the current state.
- Classes:
  - R (op 0): addu funct 6'h21, subu 6'h23, jr 6'h08
  - ori 6'h0d
  - lw 6'h23
  - sw 6'h2b
  - beq 6'h04
  - lui 6'h0f
  - jal 6'h03
  - Anything else, including sll $0 (nop), is class NOP.
- FETCH: ir_we=1, pc_we=1, pc_sel=0. Next state DECODE.
- DECODE: ab_we=1.
  - jal: pc_we=1, pc_sel=2, grf_we=1, reg_dst=2, wd_sel=2; retire; next FETCH.
  - jr: pc_we=1, pc_sel=3; retire; next FETCH.
  - NOP: retire; next FETCH.
  - All other classes go to EXEC.
- EXEC:
  - beq: alu_op=SUB, alu_b_sel=0. If zero, pc_we=1 and pc_sel=1. Retire; next FETCH.
  - lw/sw: alu_op=ADD, alu_b_sel=1, ext_op=1; next MEM.
  - addu/subu: alu_op ADD/SUB, alu_b_sel=0; next WB.
  - ori: alu_op=OR, alu_b_sel=1, ext_op=0; next WB.
  - lui: alu_op=LUI, alu_b_sel=1; next WB.
- MEM:
  - lw: mdr_we=1; next WB.
  - sw: dm_we=1; retire; next FETCH.
- WB: grf_we=1; retire; next FETCH.
  - addu/subu: reg_dst=1, wd_sel=0.
  - ori/lui: reg_dst=0, wd_sel=0.
  - lw: reg_dst=0, wd_sel=1.
- Latency in clocks: jal/jr/NOP 2, beq 3, addu/subu/ori/lui/sw 4, lw 5.
- op/funct are read only in DECODE, EXEC, MEM and WB. They are stable because the IR loads only in FETCH.
- instr_cnt: increments by 1 on every retire cycle and wraps from all-ones to 0 with no flag.
- Reset:
  - Sets state=FETCH and instr_cnt=0.
  - All enables and retire are forced to 0 during any cycle in which reset is high, including mid-instruction. No partial writes occur.
  - The first FETCH executes on the first clock after reset deasserts.
- zero is ignored in every state except EXEC with class beq.

Decomposition:
- Package mc_ctrl_pkg holds:
  - the state encodings
  - opcode and funct constants
  - alu_op codes
  - pc_sel, reg_dst and wd_sel codes
- One combinational sub-module, mc_decode, maps op/funct to a one-hot class vector (addu, subu, ori, lw, sw, beq, lui, jal, jr, nop). The FSM in mc_ctrl consumes this vector.

Test Plan:
- addu (op 0, funct 21) after reset:
  - state sequence 0,1,2,4,0
  - ir_we/pc_we only in cycle 1, grf_we=1 with reg_dst=1, wd_sel=0 only in cycle 4
  - retire at cycle 4, instr_cnt=1
- lw (op 23): 5 cycles; mdr_we in MEM, WB with wd_sel=1; ext_op=1 in EXEC. sw (op 2b): dm_we=1 exactly one cycle, grf_we never high.
- beq (op 04):
  - zero=1 gives pc_we=1 with pc_sel=1 in EXEC
  - zero=0 gives pc_we=0 in EXEC
  - both take 3 cycles
- jal (op 03): in DECODE, pc_sel=2, reg_dst=2, wd_sel=2, grf_we=1. jr (funct 08): pc_sel=3. Both take 2 cycles.
- Illegal op 3f: retires in 2 cycles with no grf_we/dm_we. Reset asserted during lw MEM: dm_we/grf_we stay 0, state_o=0 next cycle, instr_cnt=0.
- Force instr_cnt to all-ones, then retire one instruction: instr_cnt becomes 0.
